countdown_sequencer: RTL and testbench
======================================

# countdown_sequencer

Control unit for the chained BCD down-counters of the countdown timer: minutes ones (mod-10), seconds tens (mod-6) and seconds ones (mod-10). It collects three digits from the keypad and loads them into the counter chain. It then gates the 1 Hz tick into the chain's enable and stops when the chain reaches 0:00. It owns no counting arithmetic itself: the counters own the datapath, and this block sequences their load, clear and enable.

## Interface
- DONE_CYCLES, 8: clock cycles `done` stays high after expiry (≥1).
- clock  in  1  system clock, rising edge.
- clearn  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle 1 Hz pulse.
- key_valid  in  1  one-cycle strobe, keypad code valid.
- key_code  in  4  keypad digit; 0–9 accepted, 10–15 ignored.
- start  in  1  start/resume pulse.
- stop  in  1  pause/cancel pulse.
- zero_in  in  1  AND of the three counters' `zero` outputs.
- door_open  in  1  door sensor; present only with COUNTDOWN_DOOR_INTERLOCK_EN.
- data  out  12  {min, sec_tens, sec_ones} BCD entry, driven to the counters' `data`.
- loadn  out  1  active-low load strobe to all counters.
- cnt_clearn  out  1  active-low synchronous clear strobe to all counters.
- en  out  1  count enable to the seconds-ones counter.
- running  out  1  high in RUN.
- done  out  1  expiry indication.
- error  out  1  one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, ENTRY, LOAD, RUN, PAUSE, DONE. Reset state is IDLE.
- Reset values: data=000, loadn=1, cnt_clearn=1, en=0, running=0, done=0, error=0.
- IDLE:
  - A valid key shifts into `data` and moves to ENTRY.
  - start is ignored.
- ENTRY:
  - A valid key does data <= {data[7:0], key_code}; the oldest digit is discarded.
  - stop clears data to 000 and moves to IDLE.
  - start with data==000 or sec_tens>5 pulses `error` and stays in ENTRY.
  - Any other start moves to LOAD.
- LOAD: loadn=0 for exactly one cycle, then RUN.
- RUN:
  - en = tick & ~zero_in (combinational).
  - zero_in=1 moves to DONE.
  - stop moves to PAUSE.
  - Keys are ignored.
- PAUSE:
  - en=0.
  - start moves to RUN.
  - stop pulses cnt_clearn=0 for one cycle, clears data and moves to IDLE.
- DONE:
  - done=1 for DONE_CYCLES cycles, then IDLE with data cleared.
  - key_valid or stop exits to IDLE immediately.
- Priorities:
  - stop beats start.
  - start beats key_valid.
  - In RUN, zero_in beats stop.
- Keys with codes 10–15 have no effect in any state.

## Timing
- All outputs are registered except `en`.
- start sampled at edge N in ENTRY: loadn is low during cycle N+1, and running is high from edge N+2.
- zero_in is ignored in LOAD; the first RUN cycle reflects the loaded value.
- A tick coinciding with zero_in=1 produces no en pulse, so the counters never wrap below 0:00.
- A tick arriving during LOAD or PAUSE is dropped, not queued.
- Asserting clearn mid-operation returns every output to its reset value immediately. The counters are not cleared by this block in that case.

## Configuration
- COUNTDOWN_DOOR_INTERLOCK_EN defined:
  - `door_open` port exists.
  - door_open=1 in RUN forces PAUSE on the next edge.
  - start is ignored in ENTRY and PAUSE while door_open=1 (no error pulse).
- Undefined: no port and no interlock; behaviour is otherwise identical.

## Test plan
- Reset, then keys 1,3,0 and start → data=0x130, loadn low for exactly one cycle, running=1 two edges after start.
- Keys 0,7,5 and start → error pulses once, state stays ENTRY, loadn stays 1.
- In RUN, 5 ticks → 5 en pulses. stop → en=0 and ticks ignored. start resumes. stop, stop → cnt_clearn one-cycle pulse, data=000, IDLE.
- Load 0:02 with a counter model; 2 ticks → zero_in=1, third tick gives no en, done high for 8 cycles, then IDLE.
- start and stop in the same ENTRY cycle → stop wins, data=000, IDLE. key_valid and start together → start wins, digit not shifted.
- With COUNTDOWN_DOOR_INTERLOCK_EN: door_open=1 during RUN → PAUSE, en=0. start rejected while door_open=1, accepted after it drops.

Source files
------------

// File: rtl/countdown_sequencer.sv
// countdown_sequencer: sequences load / clear / enable of the external
// BCD down-counter chain (min ones, sec tens, sec ones) for a countdown timer.
// Collects three keypad digits, loads them, gates the 1 Hz tick into the
// chain enable and signals expiry when the chain reaches 0:00.
// Optional feature: define COUNTDOWN_DOOR_INTERLOCK_EN to add the i_door_open
// input, which forces PAUSE while running and blocks start while the door is open.
module countdown_sequencer #(
    parameter int DONE_CYCLES = 8
) (
    input  logic        i_clock,
    input  logic        i_clearn,
    input  logic        i_tick,
    input  logic        i_key_valid,
    input  logic [3:0]  i_key_code,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_zero_in,
`ifdef COUNTDOWN_DOOR_INTERLOCK_EN
    input  logic        i_door_open,
`endif
    output logic [11:0] o_data,
    output logic        o_loadn,
    output logic        o_cnt_clearn,
    output logic        o_en,
    output logic        o_running,
    output logic        o_done,
    output logic        o_error
);

    localparam int CW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [11:0]     r_data;
    logic [11:0]     w_data;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt;
    logic            r_loadn;
    logic            r_clrn;
    logic            w_clrn;
    logic            r_running;
    logic            r_done;
    logic            r_error;
    logic            w_error;
    logic            w_key_ok;
    logic            w_door;

`ifdef COUNTDOWN_DOOR_INTERLOCK_EN
    assign w_door = i_door_open;
`else
    assign w_door = 1'b0;
`endif

    // Only decimal digits count as keypresses; codes 10-15 are dropped everywhere.
    assign w_key_ok = i_key_valid & (i_key_code <= 4'd9);

    // Next-state, next-data, expiry counter and one-cycle strobe decode.
    always_comb begin
        w_next  = r_state;
        w_data  = r_data;
        w_cnt   = r_cnt;
        w_clrn  = 1'b1;
        w_error = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!i_stop && w_key_ok) begin
                    w_data = {r_data[7:0], i_key_code};
                    w_next = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (i_stop) begin
                    w_data = 12'h000;
                    w_next = S_IDLE;
                end else if (i_start && !w_door) begin
                    // Reject an empty entry or a seconds-tens digit the mod-6 counter cannot hold.
                    if ((r_data == 12'h000) || (r_data[7:4] > 4'd5)) begin
                        w_error = 1'b1;
                    end else begin
                        w_next = S_LOAD;
                    end
                end else if (w_key_ok) begin
                    w_data = {r_data[7:0], i_key_code};
                end
            end
            S_LOAD: begin
                w_next = S_RUN;
            end
            S_RUN: begin
                if (i_zero_in) begin
                    w_next = S_DONE;
                    w_cnt  = CW'(DONE_CYCLES - 1);
                end else if (i_stop || w_door) begin
                    w_next = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (i_stop) begin
                    w_clrn = 1'b0;
                    w_data = 12'h000;
                    w_next = S_IDLE;
                end else if (i_start && !w_door) begin
                    w_next = S_RUN;
                end
            end
            S_DONE: begin
                if (i_stop || w_key_ok || (r_cnt == '0)) begin
                    w_data = 12'h000;
                    w_next = S_IDLE;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_data = 12'h000;
                w_next = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; clearn drops everything to idle at once.
    always_ff @(posedge i_clock or negedge i_clearn) begin
        if (!i_clearn) begin
            r_state   <= S_IDLE;
            r_data    <= 12'h000;
            r_cnt     <= '0;
            r_loadn   <= 1'b1;
            r_clrn    <= 1'b1;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_data    <= w_data;
            r_cnt     <= w_cnt;
            r_loadn   <= (w_next != S_LOAD);
            r_clrn    <= w_clrn;
            // After LOAD, running rises one cycle late so the counters have settled on the new value.
            r_running <= (w_next == S_RUN) && (r_state != S_LOAD);
            r_done    <= (w_next == S_DONE);
            r_error   <= w_error;
        end
    end

    // Tick is gated combinationally; masking on zero_in keeps the chain from wrapping below 0:00.
    assign o_en         = i_tick & ~i_zero_in & (r_state == S_RUN);
    assign o_data       = r_data;
    assign o_loadn      = r_loadn;
    assign o_cnt_clearn = r_clrn;
    assign o_running    = r_running;
    assign o_done       = r_done;
    assign o_error      = r_error;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Self-checking bench for countdown_sequencer with a behavioural BCD
// down-counter chain supplying zero_in. Expected load values are queued
// when start is issued and checked when loadn is observed low.
module tb_countdown_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        zero_in;
`ifdef COUNTDOWN_DOOR_INTERLOCK_EN
    logic        door_open = 1'b0;
`endif
    logic [11:0] data;
    logic        loadn, cnt_clearn, en, running, done, error;

    int n_checks = 0;
    int n_fail = 0;
    logic [11:0] q_load[$];
    logic [11:0] cnt_model = 12'h000;

    countdown_sequencer #(.DONE_CYCLES(8)) dut (
        .i_clock(clk),
        .i_clearn(rst_n),
        .i_tick(tick),
        .i_key_valid(key_valid),
        .i_key_code(key_code),
        .i_start(start),
        .i_stop(stop),
        .i_zero_in(zero_in),
`ifdef COUNTDOWN_DOOR_INTERLOCK_EN
        .i_door_open(door_open),
`endif
        .o_data(data),
        .o_loadn(loadn),
        .o_cnt_clearn(cnt_clearn),
        .o_en(en),
        .o_running(running),
        .o_done(done),
        .o_error(error)
    );

    always #5 clk = ~clk;

    // BCD down-count of {min ones, sec tens (mod 6), sec ones}
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] m, t, o;
        m = v[11:8]; t = v[7:4]; o = v[3:0];
        if (o != 0) o = o - 1;
        else begin
            o = 4'd9;
            if (t != 0) t = t - 1;
            else begin
                t = 4'd5;
                m = (m != 0) ? m - 1 : 4'd9;
            end
        end
        return {m, t, o};
    endfunction

    // Counter chain model
    always @(posedge clk) begin
        if (!cnt_clearn)  cnt_model <= 12'h000;
        else if (!loadn)  cnt_model <= data;
        else if (en)      cnt_model <= bcd_dec(cnt_model);
    end
    assign zero_in = (cnt_model == 12'h000);

    // Scoreboard: every load cycle must match the next queued entry
    always @(negedge clk) begin
        if (rst_n && loadn === 1'b0) begin
            n_checks++;
            if (q_load.size() == 0) begin
                n_fail++;
                $display("FAIL load_unexpected: data=%h, no load queued", data);
            end else begin
                logic [11:0] exp_d;
                exp_d = q_load.pop_front();
                if (data !== exp_d) begin
                    n_fail++;
                    $display("FAIL load_data: got %h want %h", data, exp_d);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic press_key(input logic [3:0] c);
        key_valid = 1'b1; key_code = c; step(); key_valid = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic press_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic tick_obs(output logic e);
        tick = 1'b1; #1; e = en; step(); tick = 1'b0;
    endtask

    task automatic test_reset();
        tick = 1'b1;
        #12;
        n_checks++;
        if ({data, loadn, cnt_clearn, en, running, done, error} !== {12'h000, 6'b110000}) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%b%b%b%b%b%b want 000/110000",
                     data, loadn, cnt_clearn, en, running, done, error);
        end
        tick = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    task automatic test_load();
        press_key(4'd1);
        n_checks++; if (data !== 12'h001) begin n_fail++; $display("FAIL key1_data: got %h want 001", data); end
        press_key(4'd3);
        n_checks++; if (data !== 12'h013) begin n_fail++; $display("FAIL key2_data: got %h want 013", data); end
        press_key(4'd0);
        n_checks++; if (data !== 12'h130) begin n_fail++; $display("FAIL key3_data: got %h want 130", data); end
        q_load.push_back(12'h130);
        press_start();
        n_checks++; if ({loadn, running} !== 2'b00) begin n_fail++; $display("FAIL load_n1: loadn/running %b%b want 00", loadn, running); end
        step();
        n_checks++; if ({loadn, running} !== 2'b10) begin n_fail++; $display("FAIL load_n2: loadn/running %b%b want 10", loadn, running); end
        step();
        n_checks++; if ({loadn, running} !== 2'b11) begin n_fail++; $display("FAIL load_n3: loadn/running %b%b want 11", loadn, running); end
    endtask

    task automatic test_run();
        logic e;
        int en_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick_obs(e);
            if (e) en_cnt++;
        end
        n_checks++; if (en_cnt != 5) begin n_fail++; $display("FAIL run_en_pulses: got %0d want 5", en_cnt); end
        press_stop();
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL pause_running: got %b want 0", running); end
        tick_obs(e);
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL pause_en: got %b want 0", e); end
        press_start();
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL resume_running: got %b want 1", running); end
        tick_obs(e);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL resume_en: got %b want 1", e); end
        press_stop();
        press_stop();
        n_checks++; if ({cnt_clearn, data} !== {1'b0, 12'h000}) begin n_fail++; $display("FAIL cancel_clear: clearn/data %b/%h want 0/000", cnt_clearn, data); end
        step();
        n_checks++; if (cnt_clearn !== 1'b1) begin n_fail++; $display("FAIL cancel_clear_width: got %b want 1", cnt_clearn); end
    endtask

    task automatic test_expire();
        logic e;
        int hi;
        press_key(4'd0); press_key(4'd0); press_key(4'd2);
        q_load.push_back(12'h002);
        press_start();
        // tick during LOAD is dropped
        tick = 1'b1; #1;
        n_checks++; if (en !== 1'b0) begin n_fail++; $display("FAIL load_tick_en: got %b want 0", en); end
        step(); tick = 1'b0;
        tick_obs(e);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL expire_tick1: got %b want 1", e); end
        tick_obs(e);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL expire_tick2: got %b want 1", e); end
        tick_obs(e);
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL expire_tick3_at_zero: got %b want 0", e); end
        n_checks++; if ({done, running} !== 2'b10) begin n_fail++; $display("FAIL expire_done: done/running %b%b want 10", done, running); end
        hi = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) hi++;
            else break;
        end
        n_checks++; if (hi != 8) begin n_fail++; $display("FAIL done_width: got %0d cycles want 8", hi); end
        n_checks++; if (data !== 12'h000) begin n_fail++; $display("FAIL done_data_cleared: got %h want 000", data); end
        // expire again and leave DONE early with a key
        press_key(4'd0); press_key(4'd0); press_key(4'd1);
        q_load.push_back(12'h001);
        press_start(); step();
        tick_obs(e);
        step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done2_entry: got %b want 1", done); end
        press_key(4'd3);
        n_checks++; if ({done, data} !== {1'b0, 12'h000}) begin n_fail++; $display("FAIL done_key_exit: done/data %b/%h want 0/000", done, data); end
    endtask

    task automatic test_error();
        press_key(4'd0); press_key(4'd7); press_key(4'd5);
        n_checks++; if (data !== 12'h075) begin n_fail++; $display("FAIL err_entry_data: got %h want 075", data); end
        press_start();
        n_checks++; if ({error, loadn} !== 2'b11) begin n_fail++; $display("FAIL err_pulse: error/loadn %b%b want 11", error, loadn); end
        step();
        n_checks++; if ({error, loadn, running} !== 3'b010) begin n_fail++; $display("FAIL err_single: error/loadn/running %b%b%b want 010", error, loadn, running); end
        press_key(4'd2);
        n_checks++; if (data !== 12'h752) begin n_fail++; $display("FAIL err_stay_entry: got %h want 752", data); end
        press_stop();
        press_key(4'd0);
        press_start();
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL err_zero_entry: got %b want 1", error); end
        press_key(4'd12);
        n_checks++; if (data !== 12'h000) begin n_fail++; $display("FAIL bad_key_entry: got %h want 000", data); end
        press_stop();
        press_key(4'd15);
        press_start();
        n_checks++; if ({error, loadn, data} !== {2'b01, 12'h000}) begin n_fail++; $display("FAIL idle_start_ignored: error/loadn/data %b%b/%h want 01/000", error, loadn, data); end
        press_key(4'd5);
        n_checks++; if (data !== 12'h005) begin n_fail++; $display("FAIL idle_key: got %h want 005", data); end
        press_stop();
    endtask

    task automatic test_priority();
        press_key(4'd1); press_key(4'd2);
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        n_checks++; if ({loadn, error, data} !== {2'b10, 12'h000}) begin n_fail++; $display("FAIL stop_beats_start: loadn/error/data %b%b/%h want 10/000", loadn, error, data); end
        press_key(4'd4); press_key(4'd5);
        q_load.push_back(12'h045);
        start = 1'b1; key_valid = 1'b1; key_code = 4'd7; step();
        start = 1'b0; key_valid = 1'b0;
        n_checks++; if ({loadn, data} !== {1'b0, 12'h045}) begin n_fail++; $display("FAIL start_beats_key: loadn/data %b/%h want 0/045", loadn, data); end
        step(); step();
        press_key(4'd8);
        n_checks++; if ({running, data} !== {1'b1, 12'h045}) begin n_fail++; $display("FAIL run_key_ignored: running/data %b/%h want 1/045", running, data); end
        press_stop(); press_stop();
    endtask

`ifdef COUNTDOWN_DOOR_INTERLOCK_EN
    task automatic test_door();
        logic e;
        press_key(4'd0); press_key(4'd3); press_key(4'd0);
        q_load.push_back(12'h030);
        press_start(); step(); step();
        door_open = 1'b1; step();
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL door_pause: running %b want 0", running); end
        tick_obs(e);
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL door_en: got %b want 0", e); end
        press_start();
        n_checks++; if ({running, error} !== 2'b00) begin n_fail++; $display("FAIL door_start_blocked: running/error %b%b want 00", running, error); end
        door_open = 1'b0;
        press_start();
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL door_resume: running %b want 1", running); end
        press_stop(); press_stop();
        press_key(4'd1);
        door_open = 1'b1;
        press_start();
        n_checks++; if ({loadn, error} !== 2'b10) begin n_fail++; $display("FAIL door_entry_start: loadn/error %b%b want 10", loadn, error); end
        door_open = 1'b0;
        press_stop();
    endtask
`endif

    task automatic test_midreset();
        press_key(4'd2); press_key(4'd0); press_key(4'd0);
        q_load.push_back(12'h200);
        press_start(); step(); step();
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: running %b want 1", running); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({data, loadn, cnt_clearn, running, done, error} !== {12'h000, 5'b11000}) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h/%b%b%b%b%b want 000/11000",
                     data, loadn, cnt_clearn, running, done, error);
        end
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_load();
        test_run();
        test_expire();
        test_error();
        test_priority();
`ifdef COUNTDOWN_DOOR_INTERLOCK_EN
        test_door();
`endif
        test_midreset();
        n_checks++;
        if (q_load.size() != 0) begin
            n_fail++;
            $display("FAIL loads_missing: %0d queued loads never seen, want 0", q_load.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
